// File: rtl/prim_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : prim_ram_ctrl_pkg
// Brief  : FSM state encoding and byte-merge helper for prim_ram_ctrl.
// Rev    : 1.0
// ============================================================================
package prim_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_MERGE = 2'd2
    } state_e;

    // Widest supported word; callers zero-extend narrower words into this.
    localparam int unsigned C_MERGE_MAX_DW = 256;

    function automatic logic [C_MERGE_MAX_DW-1:0] byte_merge(
        input logic [C_MERGE_MAX_DW-1:0]   data,
        input logic [C_MERGE_MAX_DW-1:0]   wdata,
        input logic [C_MERGE_MAX_DW/8-1:0] be
    );
        logic [C_MERGE_MAX_DW-1:0] res;
        res = data;
        for (int i = 0; i < C_MERGE_MAX_DW/8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : prim_ram_ctrl
// Brief  : Single-port RAM controller with byte-enable read-modify-write.
// Rev    : 1.0
// ============================================================================
module prim_ram_ctrl
    import prim_ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_WIDTH-1:0]     be_q, be_d;

    logic                    w_accept;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic [C_MERGE_MAX_DW-1:0]   w_mrg_data, w_mrg_wdata, w_mrg_out;
    logic [C_MERGE_MAX_DW/8-1:0] w_mrg_be;

    assign req_ready_o = !rst_i && (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready_i);
    assign w_accept    = req_valid_i && req_ready_o;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

    always_comb begin
        w_mrg_data  = '0;
        w_mrg_wdata = '0;
        w_mrg_be    = '0;
        w_mrg_data[DATA_WIDTH-1:0]  = ram_rdata_i;
        w_mrg_wdata[DATA_WIDTH-1:0] = wdata_q;
        w_mrg_be[BE_WIDTH-1:0]      = be_q;
        w_mrg_out = byte_merge(w_mrg_data, w_mrg_wdata, w_mrg_be);
    end

    assign w_merged = w_mrg_out[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < C_MERGE_MAX_DW) begin : g_merge_pad
            logic w_pad_unused;
            assign w_pad_unused = ^w_mrg_out[C_MERGE_MAX_DW-1:DATA_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;

        if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!req_we_i) begin
                        ram_en_o   = 1'b1;
                        ram_addr_o = req_addr_i;
                        state_d    = ST_RD;
                    end else if (&req_be_i) begin
                        ram_en_o    = 1'b1;
                        ram_we_o    = 1'b1;
                        ram_addr_o  = req_addr_i;
                        ram_wdata_o = req_wdata_i;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end else if (|req_be_i) begin
                        // Partial write: fetch the old word, merge next cycle.
                        ram_en_o   = 1'b1;
                        ram_addr_o = req_addr_i;
                        addr_d     = req_addr_i;
                        wdata_d    = req_wdata_i;
                        be_d       = req_be_i;
                        state_d    = ST_MERGE;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            ST_RD: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_rdata_i;
                state_d     = ST_IDLE;
            end
            ST_MERGE: begin
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = addr_q;
                ram_wdata_o = w_merged;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset must suppress any RAM strobe, including an in-flight merge.
        if (rst_i) begin
            ram_en_o    = 1'b0;
            ram_we_o    = 1'b0;
            ram_addr_o  = '0;
            ram_wdata_o = '0;
        end
    end

endmodule
`default_nettype wire

// File: doc/prim_ram_ctrl.md
PRIM_RAM_CTRL -- requirements
Module: prim_ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, RAM word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width; must be a multiple of 8.
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  request accepted when valid and ready are both high.
REQ-007 SHALL have port req_we_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr_i  input  ADDR_WIDTH  word address.
REQ-009 SHALL have port req_wdata_i  input  DATA_WIDTH  write data.
REQ-010 SHALL have port req_be_i  input  DATA_WIDTH/8  byte enables; ignored on reads.
REQ-011 SHALL have port rsp_valid_o  output  1  response present.
REQ-012 SHALL have port rsp_ready_i  input  1  response consumed when valid and ready are both high.
REQ-013 SHALL have port rsp_rdata_o  output  DATA_WIDTH  read data; 0 for write responses.
REQ-014 SHALL have ports ram_en_o, ram_we_o  output  1 each  RAM strobe and write select.
REQ-015 SHALL have ports ram_addr_o  output  ADDR_WIDTH and ram_wdata_o  output  DATA_WIDTH  RAM address and data.
REQ-016 SHALL have port ram_rdata_i  input  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en_o=1, ram_we_o=0.

Function
REQ-017 SHALL implement the FSM states IDLE, RD (read data return) and MERGE (read-modify-write second phase).
REQ-018 SHALL drive req_ready_o = (state==IDLE) && (!rsp_valid_o || rsp_ready_i), so at most one request is outstanding.
REQ-019 SHALL drive the RAM port combinationally from req_* in the acceptance cycle and, in every other cycle except MERGE, drive ram_en_o=0.
REQ-020 Read accepted at cycle T SHALL do: RAM read at T, go to RD, capture ram_rdata_i at T+1, assert rsp_valid_o at T+2, return to IDLE.
REQ-021 Write with all req_be_i bits set, accepted at T, SHALL do: RAM write of req_wdata_i at T, rsp_valid_o at T+1, stay in IDLE.
REQ-022 Write with partial nonzero req_be_i, accepted at T, SHALL do: RAM read at T and latch addr, wdata and be; go to MERGE.
REQ-023 In MERGE at T+1 the block SHALL write the merge with ram_en_o=1, ram_we_o=1: byte i taken from the latched wdata if be[i]=1, otherwise from ram_rdata_i. rsp_valid_o SHALL assert at T+2 and the FSM SHALL return to IDLE.
REQ-024 Write with req_be_i=0 SHALL perform no RAM access and SHALL assert rsp_valid_o at T+1.
REQ-025 Each accepted request SHALL produce exactly one response, in request order.
REQ-026 rsp_valid_o and rsp_rdata_o SHALL hold stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-027 When a response is consumed and a new request is accepted in the same cycle, the block SHALL process both with no bubble.
REQ-028 A read accepted the cycle after a write completes, to the same address, SHALL return the newly written data.

Reset
REQ-029 While rst_i=1 the block SHALL hold: state=IDLE, rsp_valid_o=0, rsp_rdata_o=0, req_ready_o=0, and all ram_* outputs=0.
REQ-030 Reset in RD or MERGE SHALL abandon the operation: no RAM write, no response after reset deasserts.
REQ-031 req_ready_o SHALL rise in the first cycle after rst_i deasserts.

Structure
REQ-032 Package prim_ram_ctrl_pkg SHALL hold the FSM state enum and the byte-merge function (data, wdata, be -> merged word).
REQ-033 The block SHALL have no sub-module; the parent SHALL instantiate the RAM and tie its active-low reset to the inverse of rst_i.

Verification
REQ-034 Bench SHALL check a full write then read: write addr 0x0010, data 0xDEADBEEF, be 0xF -> ram_we_o=1 in the accept cycle, response at T+1. Read of 0x0010 -> rsp_rdata_o=0xDEADBEEF at T+2.
REQ-035 Bench SHALL check RMW: RAM word 0x11223344, write be 0x5, data 0xAABBCCDD -> MERGE writes 0x11BB33DD, then a read returns 0x11BB33DD.
REQ-036 Bench SHALL check zero enables: write be 0x0 -> ram_en_o stays 0, response at T+1 with rdata 0.
REQ-037 Bench SHALL check backpressure: rsp_ready_i=0 for 5 cycles after a read response -> rsp_rdata_o stable, req_ready_o=0. Release -> the next request is accepted in the same cycle.
REQ-038 Bench SHALL check reset mid-RMW: assert rst_i in MERGE -> no RAM write, target word unchanged, rsp_valid_o=0.
REQ-039 Bench SHALL check random traffic: 1000 random read/write/be requests with random rsp_ready_i -> responses match a reference memory model, in order.
